// File: rtl/serial_slice_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_slice_adder
//  Description : Multi-cycle WIDTH-bit adder that pushes one SLICE-bit
//                ripple slice per clock through a single slice adder, LSB
//                slice first, with a carry register linking the slices.
//                Valid/ready handshake on input and output.
//                Optional subtract mode under macro SERIAL_ADDER_SUB_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_slice_adder #(
    parameter int WIDTH = 64,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    // Guarded so a zero SLICE does not divide by zero before the check fires
    localparam int c_num_slices = (SLICE < 1) ? 1 : (WIDTH / SLICE);
    localparam int c_cnt_w      = (c_num_slices > 1) ? $clog2(c_num_slices) : 1;
    localparam logic [c_cnt_w-1:0] c_last_slice = c_cnt_w'(c_num_slices - 1);

    generate
        if (SLICE < 1) begin : g_bad_slice
            $error("serial_slice_adder: SLICE must be at least 1");
        end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
            $error("serial_slice_adder: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic [SLICE:0]     w_slice_sum;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_carry_in;

    // Subtract folds into the add path: invert B and inject the +1 as carry
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_in     = sub ? ~B : B;
    assign w_carry_in = sub ? 1'b1 : Cin;
`else
    assign w_b_in     = B;
    assign w_carry_in = Cin;
`endif

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign S         = r_sum;
    assign Cout      = r_cout;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == c_last_slice);

    // Operands shift right each cycle so the active slice is always the low
    // SLICE bits; the sum shifts in from the top and lands in place after N
    assign w_slice_sum = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]}
                       + {{SLICE{1'b0}}, r_carry};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_RUN;
            S_RUN:  if (w_last) w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture, per-slice add, carry chaining and result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= A;
                        r_b     <= w_b_in;
                        r_carry <= w_carry_in;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> SLICE;
                    r_b     <= r_b >> SLICE;
                    r_sum   <= (r_sum >> SLICE)
                             | (WIDTH'(w_slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
                    r_carry <= w_slice_sum[SLICE];
                    if (w_last) begin
                        r_cout <= w_slice_sum[SLICE];
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_slice_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_slice_adder
//  Description : Directed self-checking bench for serial_slice_adder
//                (subtract vectors included when SERIAL_ADDER_SUB_EN is set).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_slice_adder;

    localparam int WIDTH = 64;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif

    int n_checks = 0;
    int n_errors = 0;

    serial_slice_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Safety net in case the design wedges the bench
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [WIDTH:0] got,
                         input logic [WIDTH:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_op(input string tag, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic cin);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, " in_ready"}, {64'd0, in_ready}, 65'd1);
        A        = a;
        B        = b;
        Cin      = cin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Operands must be registered: scribble on the inputs after acceptance
        A        = ~a;
        B        = ~b;
        Cin      = ~cin;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic cin,
                          input logic [WIDTH-1:0] exp_s, input logic exp_c);
        int cyc;
        start_op(tag, a, b, cin);
        wait_done(cyc);
        check({tag, " latency"}, (WIDTH+1)'(cyc), (WIDTH+1)'(N));
        check({tag, " S"}, {1'b0, S}, {1'b0, exp_s});
        check({tag, " Cout"}, {64'd0, Cout}, {64'd0, exp_c});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, {64'd0, out_valid}, 65'd0);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {64'd0, out_valid}, 65'd0);
        check("reset in_ready", {64'd0, in_ready}, 65'd0);
        check("reset S", {1'b0, S}, 65'd0);
        check("reset Cout", {64'd0, Cout}, 65'd0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", {64'd0, in_ready}, 65'd1);

        run_op("add5_3", 64'd5, 64'd3, 1'b0, 64'd8, 1'b0);
        run_op("allones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1);
        run_op("msb_msb", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
               64'd0, 1'b1);
        run_op("slice_boundary", 64'h0F, 64'h01, 1'b0, 64'h10, 1'b0);
        run_op("mixed", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Result must hold in DONE while the consumer stalls; new input ignored
        start_op("hold", 64'h1234, 64'h1111, 1'b0);
        wait_done(cyc);
        check("hold latency", (WIDTH+1)'(cyc), (WIDTH+1)'(N));
        in_valid = 1'b1;
        A        = 64'hFFFF_FFFF_FFFF_FFFF;
        B        = 64'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold S", {1'b0, S}, {1'b0, 64'h2345});
            check("hold Cout", {64'd0, Cout}, 65'd0);
            check("hold out_valid", {64'd0, out_valid}, 65'd1);
            check("hold in_ready", {64'd0, in_ready}, 65'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold release out_valid", {64'd0, out_valid}, 65'd0);
        check("hold release in_ready", {64'd0, in_ready}, 65'd1);
        run_op("after_hold", 64'h22, 64'h33, 1'b0, 64'h55, 1'b0);

        // Reset in the middle of an operation, at slice 7
        start_op("abort", 64'hAAAA, 64'h5555, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort out_valid", {64'd0, out_valid}, 65'd0);
        check("abort S", {1'b0, S}, 65'd0);
        check("abort Cout", {64'd0, Cout}, 65'd0);
        check("abort in_ready in rst", {64'd0, in_ready}, 65'd0);
        rst = 1'b0;
        #1;
        check("abort in_ready", {64'd0, in_ready}, 65'd1);
        // Aborted op must never complete; stray out_ready must be harmless
        out_ready = 1'b1;
        repeat (N + 4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("abort no result", {64'd0, out_valid}, 65'd0);
        run_op("after_abort", 64'd1, 64'd1, 1'b0, 64'd2, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op("sub10_3", 64'd10, 64'd3, 1'b0, 64'd7, 1'b1);
        run_op("sub3_10", 64'd3, 64'd10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
        sub = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
